// File: rtl/lfsr_seq_checker.sv
// Receive-side LFSR sequence checker: self-seeds from the incoming stream,
// then predicts each valid bit and reports lock, error pulses and a count.
module lfsr_seq_checker #(
  parameter int              WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS      = 4'b1100,
  parameter int              CNT_W      = 8,
  parameter int              WINDOW     = 16,
  parameter int              ERR_THRESH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W = $clog2(WIDTH);
  localparam int WIN_W  = $clog2(WINDOW + 1);
  localparam int ERR_W  = $clog2(ERR_THRESH + 1);

  typedef enum logic {
    SYNC,
    CHECK
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   s, s_n;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [WIN_W-1:0]   win_cnt, win_cnt_n;
  logic [ERR_W-1:0]   win_err, win_err_n;
  logic               bit_err_n;
  logic [CNT_W-1:0]   err_count_n;
  logic               e;
  logic               mis;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= SYNC;
      s         <= '0;
      fill      <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      bit_err   <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      s         <= s_n;
      fill      <= fill_n;
      win_cnt   <= win_cnt_n;
      win_err   <= win_err_n;
      bit_err   <= bit_err_n;
      err_count <= err_count_n;
    end
  end

  assign e   = ^(s & TAPS);
  assign mis = in_bit ^ e;

  always_comb begin
    state_n     = state;
    s_n         = s;
    fill_n      = fill;
    win_cnt_n   = win_cnt;
    win_err_n   = win_err;
    bit_err_n   = 1'b0;
    err_count_n = err_count;
    if (in_valid) begin
      unique case (state)
        SYNC: begin
          s_n = {s[WIDTH-2:0], in_bit};
          if (fill == FILL_W'(WIDTH - 1)) begin
            fill_n = '0;
            // an all-zero seed would lock onto the dead state
            if (s_n != '0) begin
              state_n   = CHECK;
              win_cnt_n = '0;
              win_err_n = '0;
            end
          end else begin
            fill_n = fill + FILL_W'(1);
          end
        end
        CHECK: begin
          s_n       = {s[WIDTH-2:0], e};
          bit_err_n = mis;
          if (mis && err_count != '1)
            err_count_n = err_count + CNT_W'(1);
          if (mis && win_err == ERR_W'(ERR_THRESH - 1)) begin
            state_n   = SYNC;
            fill_n    = '0;
            win_cnt_n = '0;
            win_err_n = '0;
          end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
            win_cnt_n = '0;
            win_err_n = '0;
          end else begin
            win_cnt_n = win_cnt + WIN_W'(1);
            win_err_n = win_err + ERR_W'(mis);
          end
        end
        default: state_n = SYNC;
      endcase
    end
    if (clr_cnt)
      err_count_n = '0;
  end

  assign locked = (state == CHECK);

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: lock, errors, windows, saturation,
// count clear and async reset, against hand-derived x^4+x^3+1 sequences.
module tb_lfsr_seq_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       locked;
  logic       bit_err;
  logic [7:0] err_count;

  int n_vec = 0;
  int n_bad = 0;

  // bits following seed 1,0,0,1; pat[i] is post-seed bit i (period 15)
  logic [14:0] pat = 15'b100100011110101;

  lfsr_seq_checker dut (
    .clock     (clock),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .bit_err   (bit_err),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic b, input logic clr = 1'b0);
    @(negedge clock);
    in_bit   = b;
    in_valid = 1'b1;
    clr_cnt  = clr;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
    in_bit   = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic seed();
    send(1'b1); send(1'b0); send(1'b0); send(1'b1);
  endtask

  initial begin
    #12;
    check("rst_locked", locked, 0);
    check("rst_bit_err", bit_err, 0);
    check("rst_count", err_count, 0);
    reset = 1'b1;

    // 1: clean lock and run
    send(1'b1); send(1'b0); send(1'b0);
    check("t1_pre_lock", locked, 0);
    send(1'b1);
    check("t1_lock", locked, 1);
    for (int i = 0; i < 7; i++) begin
      send(pat[i]);
      check("t1_no_err", bit_err, 0);
    end
    check("t1_count", err_count, 0);
    check("t1_still_locked", locked, 1);

    // 2: single corrupted bit
    do_reset();
    seed();
    for (int i = 0; i < 5; i++) send(pat[i]);
    send(~pat[5]);
    check("t2_err_pulse", bit_err, 1);
    check("t2_count", err_count, 1);
    send(pat[6]);
    check("t2_pulse_end", bit_err, 0);
    check("t2_locked", locked, 1);
    check("t2_count_hold", err_count, 1);

    // 3: degenerate zero seed, then valid seed
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b0);
    check("t3_zero_seed", locked, 0);
    send(1'b1); send(1'b0); send(1'b0);
    check("t3_7th", locked, 0);
    send(1'b1);
    check("t3_8th", locked, 1);
    send(pat[0]);
    check("t3_no_err", bit_err, 0);

    // 4: four errors in one window lose lock, reseed relocks
    do_reset();
    seed();
    send(~pat[0]); send(pat[1]); send(~pat[2]); send(~pat[3]);
    check("t4_3err_locked", locked, 1);
    send(~pat[4]);
    check("t4_unlock", locked, 0);
    check("t4_last_pulse", bit_err, 1);
    check("t4_count", err_count, 4);
    seed();
    check("t4_relock", locked, 1);
    send(pat[0]);
    check("t4_relock_ok", bit_err, 0);
    check("t4_count_kept", err_count, 4);

    // window boundary: 3 errors per window does not unlock
    do_reset();
    seed();
    for (int i = 0; i < 16; i++) send(i < 3 ? ~pat[i % 15] : pat[i % 15]);
    check("win1_locked", locked, 1);
    for (int i = 16; i < 19; i++) send(~pat[i % 15]);
    check("win2_locked", locked, 1);
    check("win2_count", err_count, 6);
    send(~pat[19 % 15]);
    check("win2_unlock", locked, 0);
    check("win2_count4", err_count, 7);

    // 5: stretched stream with idle cycles
    do_reset();
    send(1'b1); idle(); send(1'b0); idle();
    send(1'b0); idle(); send(1'b1);
    check("t5_lock", locked, 1);
    idle();
    check("t5_idle_lock", locked, 1);
    for (int i = 0; i < 7; i++) begin
      send(pat[i]);
      check("t5_no_err", bit_err, 0);
      idle();
      check("t5_idle_err", bit_err, 0);
    end
    check("t5_count", err_count, 0);

    // 6: saturation, clear priority, async reset
    do_reset();
    for (int r = 0; r < 63; r++) begin
      seed();
      for (int k = 0; k < 4; k++) send(~pat[k]);
    end
    check("t6_252", err_count, 252);
    seed();
    for (int k = 0; k < 3; k++) send(~pat[k]);
    check("t6_255", err_count, 255);
    send(~pat[3]);
    check("t6_sat", err_count, 255);
    check("t6_sat_pulse", bit_err, 1);
    seed();
    send(~pat[0], 1'b1);
    check("t6_clr_wins", err_count, 0);
    check("t6_clr_pulse", bit_err, 1);
    check("t6_clr_lock", locked, 1);
    send(~pat[1]);
    check("t6_after_clr", err_count, 1);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("t6_arst_locked", locked, 0);
    check("t6_arst_count", err_count, 0);
    check("t6_arst_bit_err", bit_err, 0);
    @(negedge clock);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
